// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard scoreboard.
//   entry_t     - one tracked in-flight instruction {valid, wr, rd, is_load}
//   fwd_sel_e   - operand source select encodings (regfile / EXWB ALU / EXWB DMEM)
//   sat_inc     - saturating increment for counters up to MAX_CNT_W bits
package hazard_pkg;

   // Entries carry the widest supported register address; narrower
   // instances zero-extend on entry and on compare.
   localparam int unsigned MAX_AW    = 16;
   localparam int unsigned MAX_CNT_W = 32;

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [MAX_AW-1:0] rd;
      logic              is_load;
   } entry_t;

   localparam entry_t BUBBLE = '0;

   typedef enum logic [1:0] {
      FWD_REG  = 2'd0,
      FWD_ALU  = 2'd1,
      FWD_DMEM = 2'd2
   } fwd_sel_e;

   // Increment v, holding at the all-ones value of a w-bit counter.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                    input int unsigned         w);
      logic [MAX_CNT_W-1:0] top;
      if (w >= MAX_CNT_W) top = '1;
      else                top = (MAX_CNT_W'(1) << w) - MAX_CNT_W'(1);
      return (v >= top) ? v : v + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: compares one ID source register against every tracked entry.
//   src, used        - source address and its read-enable
//   entries          - tracked stages, entry 0 = EX, entry DEPTH-1 = WB
//   any_young_match  - hit in entries 0..DEPTH-2 (never forwardable)
//   wb_match         - hit in entry DEPTH-1
//   wb_is_load       - entry DEPTH-1 carries a load result
module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW  = 6,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned R0_ZERO = 0
) (
   input  logic [REG_AW-1:0] src,
   input  logic              used,
   input  entry_t            entries [DEPTH],
   output logic              any_young_match,
   output logic              wb_match,
   output logic              wb_is_load
);

   logic             src_is_r0;
   logic [DEPTH-1:0] hit;

   assign src_is_r0 = (R0_ZERO != 0) && (src == '0);

   always_comb begin
      hit             = '0;
      any_young_match = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         hit[i] = used & ~src_is_r0 & entries[i].valid & entries[i].wr &
                  (entries[i].rd == MAX_AW'(src));
      end
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
         any_young_match = any_young_match | hit[i];
      end
   end

   assign wb_match   = hit[DEPTH-1];
   assign wb_is_load = entries[DEPTH-1].is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW-hazard stall / branch-flush controller for the IF/ID/EX/WB core.
// Tracks DEPTH in-flight writers after ID, stalls ID on a RAW hit, flushes on a taken
// WB branch, and counts stall and flush cycles (saturating).
// Ports:
//   clock, reset (sync, active-high)
//   id_valid, id_rs/id_rs_used, id_rt/id_rt_used, id_rd/id_rd_wr, id_is_load - ID instruction
//   br_taken                 - WB-stage branch/jump taken
//   stall, flush             - PC/IFID hold + IDEX bubble, IFID/IDEX invalidate
//   fwd_a_sel, fwd_b_sel     - IDEX operand sources (0 regfile, 1 EXWB ALU, 2 EXWB DMEM)
//   stall_cnt, flush_cnt     - saturating perf counters
// Build option: define FORWARD_EN to forward from the WB entry instead of stalling on it.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW  = 6,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned R0_ZERO = 0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic              id_rs_used,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_wr,
   input  logic              id_is_load,
   input  logic              br_taken,
   output logic              stall,
   output logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   entry_t pipe [DEPTH];
   entry_t id_entry;
   logic   young_a, wb_a, wb_ld_a;
   logic   young_b, wb_b, wb_ld_b;
   logic   hazard;
   logic   issue;

   hazard_src_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)) u_match_rs (
      .src             (id_rs),
      .used            (id_rs_used),
      .entries         (pipe),
      .any_young_match (young_a),
      .wb_match        (wb_a),
      .wb_is_load      (wb_ld_a)
   );

   hazard_src_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)) u_match_rt (
      .src             (id_rt),
      .used            (id_rt_used),
      .entries         (pipe),
      .any_young_match (young_b),
      .wb_match        (wb_b),
      .wb_is_load      (wb_ld_b)
   );

`ifdef FORWARD_EN
   assign hazard = id_valid & (young_a | young_b);
`else
   assign hazard = id_valid & (young_a | young_b | wb_a | wb_b);
   logic unused_wb_ld;
   assign unused_wb_ld = wb_ld_a ^ wb_ld_b;
`endif

   always_comb begin
      stall     = 1'b0;
      flush     = 1'b0;
      fwd_a_sel = FWD_REG;
      fwd_b_sel = FWD_REG;
      if (!reset) begin
         flush = br_taken;
         // A taken branch kills the ID instruction, so its hazard is moot.
         stall = hazard & ~br_taken;
`ifdef FORWARD_EN
         if (id_valid && !stall) begin
            if (wb_a) fwd_a_sel = wb_ld_a ? FWD_DMEM : FWD_ALU;
            if (wb_b) fwd_b_sel = wb_ld_b ? FWD_DMEM : FWD_ALU;
         end
`endif
      end
   end

   assign issue = id_valid & ~stall & ~flush;

   always_comb begin
      id_entry         = BUBBLE;
      id_entry.valid   = 1'b1;
      id_entry.wr      = id_rd_wr;
      id_entry.rd      = MAX_AW'(id_rd);
      id_entry.is_load = id_is_load;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= BUBBLE;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         pipe[0] <= issue ? id_entry : BUBBLE;
         // Flush clears everything younger than WB; the WB slot still shifts.
         for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe[i] <= (flush && (i + 1 < DEPTH)) ? BUBBLE : pipe[i-1];
         end
         if (stall) stall_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(stall_cnt), CNT_W));
         if (flush) flush_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(flush_cnt), CNT_W));
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three scoreboard instances (different DEPTH / R0_ZERO / CNT_W /
// REG_AW) share one stimulus stream; a behavioural model checks every output each cycle,
// and directed scenarios pin hand-computed values. Honours FORWARD_EN like the RTL.
module tb_hazard_scoreboard;

   localparam int NI = 3;
   localparam int DEP [NI] = '{2, 3, 1};
   localparam int R0  [NI] = '{0, 1, 0};
   localparam int CW  [NI] = '{16, 4, 8};
   localparam int AW  [NI] = '{6, 6, 3};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       id_valid = 1'b0;
   logic [5:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_rd_wr = 1'b0, id_is_load = 1'b0;
   logic       br_taken = 1'b0;

   logic       st [NI];
   logic       fl [NI];
   logic [1:0] fa [NI];
   logic [1:0] fb [NI];
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;
   logic [7:0]  sc2, fc2;

   always #5 clock = ~clock;

   hazard_scoreboard #(.REG_AW(6), .DEPTH(2), .R0_ZERO(0), .CNT_W(16)) u0 (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .br_taken(br_taken),
      .stall(st[0]), .flush(fl[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
      .stall_cnt(sc0), .flush_cnt(fc0));

   hazard_scoreboard #(.REG_AW(6), .DEPTH(3), .R0_ZERO(1), .CNT_W(4)) u1 (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .br_taken(br_taken),
      .stall(st[1]), .flush(fl[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
      .stall_cnt(sc1), .flush_cnt(fc1));

   hazard_scoreboard #(.REG_AW(3), .DEPTH(1), .R0_ZERO(0), .CNT_W(8)) u2 (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs[2:0]), .id_rs_used(id_rs_used), .id_rt(id_rt[2:0]), .id_rt_used(id_rt_used),
      .id_rd(id_rd[2:0]), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .br_taken(br_taken),
      .stall(st[2]), .flush(fl[2]), .fwd_a_sel(fa[2]), .fwd_b_sel(fb[2]),
      .stall_cnt(sc2), .flush_cnt(fc2));

   // Model: per instance, a list of in-flight instructions indexed by age (0 = EX).
   bit mv  [NI][8];
   bit mw  [NI][8];
   bit mld [NI][8];
   int mrd [NI][8];
   int msc [NI];
   int mfc [NI];

   int  checks  = 0;
   int  passed  = 0;
   bit  running = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int get_sc(input int k);
      case (k)
         0:       return int'(sc0);
         1:       return int'(sc1);
         default: return int'(sc2);
      endcase
   endfunction

   function automatic int get_fc(input int k);
      case (k)
         0:       return int'(fc0);
         1:       return int'(fc1);
         default: return int'(fc2);
      endcase
   endfunction

   function automatic bit writes_to(input int k, input int age, input int src);
      return mv[k][age] && mw[k][age] && (mrd[k][age] == src);
   endfunction

   task automatic model_out(input int k, output int e_st, output int e_fl,
                            output int e_fa, output int e_fb);
      int  mask, sa, sb, oldest;
      bit  ya, yb, wa, wb, haz;
      mask   = (1 << AW[k]) - 1;
      sa     = int'(id_rs) & mask;
      sb     = int'(id_rt) & mask;
      oldest = DEP[k] - 1;
      ya = 0; yb = 0;
      for (int age = 0; age < oldest; age++) begin
         if (id_rs_used && !(R0[k] != 0 && sa == 0) && writes_to(k, age, sa)) ya = 1;
         if (id_rt_used && !(R0[k] != 0 && sb == 0) && writes_to(k, age, sb)) yb = 1;
      end
      wa = id_rs_used && !(R0[k] != 0 && sa == 0) && writes_to(k, oldest, sa);
      wb = id_rt_used && !(R0[k] != 0 && sb == 0) && writes_to(k, oldest, sb);
`ifdef FORWARD_EN
      haz = id_valid && (ya || yb);
`else
      haz = id_valid && (ya || yb || wa || wb);
`endif
      e_st = 0; e_fl = 0; e_fa = 0; e_fb = 0;
      if (!reset) begin
         e_fl = int'(br_taken);
         e_st = (haz && !br_taken) ? 1 : 0;
`ifdef FORWARD_EN
         if (id_valid && e_st == 0) begin
            if (wa) e_fa = mld[k][oldest] ? 2 : 1;
            if (wb) e_fb = mld[k][oldest] ? 2 : 1;
         end
`endif
      end
   endtask

   always @(posedge clock) begin
      for (int k = 0; k < NI; k++) begin
         int e_st, e_fl, e_fa, e_fb, top;
         model_out(k, e_st, e_fl, e_fa, e_fb);
         top = (1 << CW[k]) - 1;
         if (reset) begin
            for (int a = 0; a < 8; a++) mv[k][a] = 0;
            msc[k] = 0;
            mfc[k] = 0;
         end else begin
            for (int a = DEP[k] - 1; a > 0; a--) begin
               mv[k][a] = mv[k][a-1]; mw[k][a] = mw[k][a-1];
               mrd[k][a] = mrd[k][a-1]; mld[k][a] = mld[k][a-1];
            end
            mv[k][0]  = id_valid && e_st == 0 && e_fl == 0;
            mw[k][0]  = id_rd_wr;
            mrd[k][0] = int'(id_rd) & ((1 << AW[k]) - 1);
            mld[k][0] = id_is_load;
            if (e_fl != 0)
               for (int a = 0; a < DEP[k] - 1; a++) mv[k][a] = 0;
            if (e_st != 0 && msc[k] < top) msc[k]++;
            if (e_fl != 0 && mfc[k] < top) mfc[k]++;
         end
      end
   end

   always @(negedge clock) begin
      if (running) begin
         for (int k = 0; k < NI; k++) begin
            int e_st, e_fl, e_fa, e_fb;
            model_out(k, e_st, e_fl, e_fa, e_fb);
            chk($sformatf("u%0d.stall", k), int'(st[k]), e_st);
            chk($sformatf("u%0d.flush", k), int'(fl[k]), e_fl);
            chk($sformatf("u%0d.fwd_a_sel", k), int'(fa[k]), e_fa);
            chk($sformatf("u%0d.fwd_b_sel", k), int'(fb[k]), e_fb);
            chk($sformatf("u%0d.stall_cnt", k), get_sc(k), msc[k]);
            chk($sformatf("u%0d.flush_cnt", k), get_fc(k), mfc[k]);
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input int rd, input bit wr, input bit ld, input bit br);
      id_valid   = v;
      id_rs      = 6'(rs);  id_rs_used = rsu;
      id_rt      = 6'(rt);  id_rt_used = rtu;
      id_rd      = 6'(rd);  id_rd_wr   = wr;
      id_is_load = ld;
      br_taken   = br;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         cyc();
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      @(posedge clock);
      #1 running = 1'b1;
      // reset held 3 cycles with a live source on the ID port
      repeat (3) begin
         #2;
         chk("reset.stall", int'(st[0]), 0);
         chk("reset.flush", int'(fl[0]), 0);
         chk("reset.stall_cnt", int'(sc0), 0);
         cyc();
      end
      reset = 1'b0;
      #2 chk("release.stall", int'(st[0]), 0);

      // back-to-back RAW: writer rd=5, reader rs=5
      cyc(); drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
      #2 chk("raw.writer_stall", int'(st[0]), 0);
      cyc(); drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      #2 chk("raw.stall_c1", int'(st[0]), 1);
      cyc();
`ifdef FORWARD_EN
      #2 chk("raw.stall_c2", int'(st[0]), 0);
      chk("raw.fwd_alu", int'(fa[0]), 1);
`else
      #2 chk("raw.stall_c2", int'(st[0]), 1);
`endif
      cyc();
      #2 chk("raw.stall_c3", int'(st[0]), 0);
`ifdef FORWARD_EN
      chk("raw.stall_cnt", int'(sc0), 1);
`else
      chk("raw.stall_cnt", int'(sc0), 2);
`endif

      // load writer rd=7, reader rs=7
      cyc(); drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
      cyc(); drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
      #2 chk("ld.stall_c1", int'(st[0]), 1);
      cyc();
`ifdef FORWARD_EN
      #2 chk("ld.fwd_dmem", int'(fa[0]), 2);
`else
      #2 chk("ld.stall_c2", int'(st[0]), 1);
`endif
      idle(3);

      // branch taken while rt=3 hazards
      cyc(); drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
      cyc(); drive(1, 0, 0, 3, 1, 0, 0, 0, 1);
      #2 chk("br.flush", int'(fl[0]), 1);
      chk("br.stall", int'(st[0]), 0);
      chk("br.u1_stall", int'(st[1]), 0);
      cyc(); drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
      #2 chk("br.flush_after", int'(fl[0]), 0);
      chk("br.flush_cnt", int'(fc0), 1);
      chk("br.u1_flush_cnt", int'(fc1), 1);
      chk("br.u1_entries_cleared", int'(st[1]), 0);
`ifdef FORWARD_EN
      chk("br.u0_wb_kept", int'(fb[0]), 1);
`else
      chk("br.u0_wb_kept", int'(st[0]), 1);
`endif
      idle(3);

      // register 0 writer / reader
      cyc(); drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(); drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
      #2 chk("r0.u0_stall", int'(st[0]), 1);
      chk("r0.u1_stall", int'(st[1]), 0);
      idle(3);

      // reset asserted mid-stall
      cyc(); drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
      cyc(); drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
      #2 chk("rst_mid.stall", int'(st[0]), 1);
      cyc(); reset = 1'b1;
      #2 chk("rst_mid.in_reset", int'(st[0]), 0);
      cyc(); reset = 1'b0;
      #2 chk("rst_mid.released", int'(st[0]), 0);
      idle(3);

      // saturation of the 4-bit counter on u1
      for (int n = 0; n < 10; n++) begin
         cyc(); drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
         cyc(); drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
         repeat (3) cyc();
         if (n == 7) begin
            #2 chk("sat.u1_stall_cnt", int'(sc1), 15);
         end
      end
      #2 chk("sat.u1_hold", int'(sc1), 15);
      idle(3);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 3) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
               int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      end
      cyc();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      #1 running = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
